// File: rtl/store_queue_pkg.sv
// Shared types for the store queue: branch bus layout, queue entry, wrap-safe sqN ordering.
package store_queue_pkg;

  localparam int SQN_W = 6;

  typedef logic [SQN_W-1:0] sqn_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    sqn_t        sqN;
    sqn_t        storeSqN;
    sqn_t        loadSqN;
    logic        flush;
  } branch_t;

  typedef struct packed {
    logic        valid;
    sqn_t        sqN;
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } sq_entry_t;

  // Sign of the 6-bit modular difference decides age, so ordering survives wrap.
  function automatic logic sqn_older(input sqn_t a, input sqn_t b);
    sqn_t d;
    d = a - b;
    return d[SQN_W-1];
  endfunction

  function automatic logic sqn_younger(input sqn_t a, input sqn_t b);
    sqn_t d;
    d = a - b;
    return !d[SQN_W-1] && (d != '0);
  endfunction

endpackage

// File: rtl/store_queue_fwd_mux.sv
// Per-byte select of the youngest buffered store older than the load at the same word address.
// Purely combinational; the caller registers the result.
module store_fwd_mux
  import store_queue_pkg::*;
#(
  parameter int NUM_ENTRIES = 8
) (
  input  sq_entry_t   entries [NUM_ENTRIES],
  input  logic [29:0] ld_addr,
  input  sqn_t        ld_sqN,
  output logic [31:0] fwd_data,
  output logic [3:0]  fwd_mask
);

  sqn_t best_sqn [4];

  always_comb begin
    fwd_data = '0;
    fwd_mask = '0;
    for (int b = 0; b < 4; b++) best_sqn[b] = '0;
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (entries[i].valid && entries[i].mask[b] && entries[i].addr == ld_addr &&
            sqn_older(entries[i].sqN, ld_sqN) &&
            (!fwd_mask[b] || sqn_older(best_sqn[b], entries[i].sqN))) begin
          fwd_mask[b]          = 1'b1;
          best_sqn[b]          = entries[i].sqN;
          fwd_data[8*b +: 8]   = entries[i].data[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/store_queue.sv
// Speculative store buffer: holds stores in storeSqN order, drains committed head to the D-cache
// with zero added latency (stalls while IN_memReady is low), forwards bytes to loads one cycle later.
module store_queue
  import store_queue_pkg::*;
#(
  parameter int NUM_ENTRIES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  commitSqN,
  input  logic        IN_valid,
  input  logic        IN_isLoad,
  input  logic [31:0] IN_addr,
  input  logic [31:0] IN_data,
  input  logic [3:0]  IN_wmask,
  input  logic [5:0]  IN_sqN,
  input  logic [5:0]  IN_storeSqN,
  input  logic [51:0] IN_branch,
  input  logic        IN_memReady,
  output logic        OUT_memValid,
  output logic [31:0] OUT_memAddr,
  output logic [31:0] OUT_memData,
  output logic [3:0]  OUT_memMask,
  output logic        OUT_fwdValid,
  output logic [31:0] OUT_fwdData,
  output logic [3:0]  OUT_fwdMask,
  output logic [5:0]  OUT_maxStoreSqN,
  output logic        OUT_empty
);

  localparam int K = $clog2(NUM_ENTRIES);

  sq_entry_t              ent     [NUM_ENTRIES];
  sq_entry_t              ent_nxt [NUM_ENTRIES];
  sqn_t                   base, base_nxt;
  branch_t                br;
  logic                   op_ok, do_enq, do_ld, do_drain;
  logic [K-1:0]           enq_slot;
  logic [NUM_ENTRIES-1:0] valid_nxt;
  logic [31:0]            mux_data;
  logic [3:0]             mux_mask;
  logic                   unused_bits;

  assign br          = IN_branch;
  assign unused_bits = ^{br.pc, br.loadSqN, IN_addr[1:0]};

  // Ops younger than a resolving branch are on the wrong path and are dropped.
  assign op_ok    = IN_valid && (!br.valid || !sqn_younger(IN_sqN, br.sqN));
  assign do_enq   = op_ok && !IN_isLoad;
  assign do_ld    = op_ok && IN_isLoad;

  assign OUT_memValid = ent[0].valid && sqn_younger(commitSqN, ent[0].sqN) && !br.valid;
  assign OUT_memAddr  = {ent[0].addr, 2'b00};
  assign OUT_memData  = ent[0].data;
  assign OUT_memMask  = ent[0].mask;
  assign do_drain     = OUT_memValid && IN_memReady;

  store_fwd_mux #(.NUM_ENTRIES(NUM_ENTRIES)) u_fwd (
    .entries  (ent),
    .ld_addr  (IN_addr[31:2]),
    .ld_sqN   (IN_sqN),
    .fwd_data (mux_data),
    .fwd_mask (mux_mask)
  );

  always_comb begin
    ent_nxt  = ent;
    base_nxt = base;
    if (br.valid) begin
      for (int i = 0; i < NUM_ENTRIES; i++)
        if (sqn_younger(ent[i].sqN, br.sqN)) ent_nxt[i].valid = 1'b0;
      if (br.flush) base_nxt = br.storeSqN;
    end else if (do_drain) begin
      for (int i = 0; i < NUM_ENTRIES - 1; i++) ent_nxt[i] = ent[i+1];
      ent_nxt[NUM_ENTRIES-1] = '0;
      base_nxt = base + 1'b1;
    end
    // Slot is relative to the post-drain base, and overrides the shift clear.
    enq_slot = IN_storeSqN[K-1:0] - base_nxt[K-1:0];
    if (do_enq) begin
      ent_nxt[enq_slot].valid = 1'b1;
      ent_nxt[enq_slot].sqN   = IN_sqN;
      ent_nxt[enq_slot].addr  = IN_addr[31:2];
      ent_nxt[enq_slot].data  = IN_data;
      ent_nxt[enq_slot].mask  = IN_wmask;
    end
    for (int i = 0; i < NUM_ENTRIES; i++) valid_nxt[i] = ent_nxt[i].valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) ent[i] <= '0;
      base            <= '0;
      OUT_fwdValid    <= 1'b0;
      OUT_fwdData     <= '0;
      OUT_fwdMask     <= '0;
      OUT_maxStoreSqN <= SQN_W'(NUM_ENTRIES - 1);
      OUT_empty       <= 1'b1;
    end else begin
      if (do_enq)
        assert (sqn_t'(IN_storeSqN - base_nxt) < sqn_t'(NUM_ENTRIES));
      ent             <= ent_nxt;
      base            <= base_nxt;
      OUT_fwdValid    <= do_ld;
      OUT_fwdData     <= do_ld ? mux_data : '0;
      OUT_fwdMask     <= do_ld ? mux_mask : '0;
      OUT_maxStoreSqN <= base_nxt + SQN_W'(NUM_ENTRIES - 1);
      OUT_empty       <= ~|valid_nxt;
    end
  end

endmodule

// File: tb/tb_store_queue.sv
// Directed + random bench for store_queue against a storeSqN-indexed behavioural model.
module tb_store_queue;

  localparam int N = 8;

  logic        clk, rst;
  logic [5:0]  commitSqN;
  logic        IN_valid, IN_isLoad;
  logic [31:0] IN_addr, IN_data;
  logic [3:0]  IN_wmask;
  logic [5:0]  IN_sqN, IN_storeSqN;
  logic [51:0] IN_branch;
  logic        IN_memReady;
  logic        OUT_memValid, OUT_fwdValid, OUT_empty;
  logic [31:0] OUT_memAddr, OUT_memData, OUT_fwdData;
  logic [3:0]  OUT_memMask, OUT_fwdMask;
  logic [5:0]  OUT_maxStoreSqN;

  logic       bv, bflush;
  logic [5:0] bsqn, bssqn;
  assign IN_branch = {bv, 32'h0, bsqn, bssqn, 6'd0, bflush};

  store_queue #(.NUM_ENTRIES(N)) dut (
    .clk(clk), .rst(rst), .commitSqN(commitSqN),
    .IN_valid(IN_valid), .IN_isLoad(IN_isLoad), .IN_addr(IN_addr), .IN_data(IN_data),
    .IN_wmask(IN_wmask), .IN_sqN(IN_sqN), .IN_storeSqN(IN_storeSqN), .IN_branch(IN_branch),
    .IN_memReady(IN_memReady),
    .OUT_memValid(OUT_memValid), .OUT_memAddr(OUT_memAddr), .OUT_memData(OUT_memData),
    .OUT_memMask(OUT_memMask), .OUT_fwdValid(OUT_fwdValid), .OUT_fwdData(OUT_fwdData),
    .OUT_fwdMask(OUT_fwdMask), .OUT_maxStoreSqN(OUT_maxStoreSqN), .OUT_empty(OUT_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: stores kept by storeSqN (mod 64), head is m_base.
  bit          m_v    [64];
  logic [5:0]  m_sqn  [64];
  logic [29:0] m_addr [64];
  logic [31:0] m_data [64];
  logic [3:0]  m_mask [64];
  int          m_base;

  function automatic int sd(input int a, input int b);
    int d;
    d = (a - b) & 63;
    return (d >= 32) ? d - 64 : d;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_v[i] = 1'b0;
    m_base = 0;
  endtask

  task automatic idle();
    IN_valid = 0; IN_isLoad = 0; IN_addr = 0; IN_data = 0; IN_wmask = 0;
    IN_sqN = 0; IN_storeSqN = 0; bv = 0; bflush = 0; bsqn = 0; bssqn = 0;
  endtask

  task automatic st(input int sqn, input int ssqn, input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] m);
    IN_valid = 1; IN_isLoad = 0; IN_sqN = 6'(sqn); IN_storeSqN = 6'(ssqn);
    IN_addr = a; IN_data = d; IN_wmask = m;
  endtask

  task automatic ld(input int sqn, input logic [31:0] a);
    IN_valid = 1; IN_isLoad = 1; IN_sqN = 6'(sqn); IN_addr = a;
  endtask

  // One clock: check combinational drain outputs, advance the model, check registered outputs.
  task automatic step();
    bit          emv, ok, eld, rst_at;
    logic [3:0]  emask;
    logic [31:0] edata, bmask;
    int          s;
    #1;
    rst_at = rst;
    emv = m_v[m_base] && sd(commitSqN, m_sqn[m_base]) > 0 && !bv;
    check("memValid", {31'd0, OUT_memValid}, {31'd0, emv});
    if (emv) begin
      check("memAddr", OUT_memAddr, {m_addr[m_base], 2'b00});
      check("memData", OUT_memData, m_data[m_base]);
      check("memMask", {28'd0, OUT_memMask}, {28'd0, m_mask[m_base]});
    end
    ok  = IN_valid && (!bv || sd(IN_sqN, bsqn) <= 0);
    eld = ok && IN_isLoad && !rst_at;
    emask = 0; edata = 0;
    if (eld)
      for (int j = 0; j < N; j++) begin
        s = (m_base + j) & 63;
        if (m_v[s] && m_addr[s] == IN_addr[31:2] && sd(m_sqn[s], IN_sqN) < 0)
          for (int b = 0; b < 4; b++)
            if (m_mask[s][b]) begin
              emask[b] = 1'b1;
              edata[8*b +: 8] = m_data[s][8*b +: 8];
            end
      end
    if (rst_at) model_reset();
    else begin
      if (bv) begin
        for (int i = 0; i < 64; i++) if (sd(m_sqn[i], bsqn) > 0) m_v[i] = 1'b0;
        if (bflush) m_base = bssqn;
      end else if (emv && IN_memReady) begin
        m_v[m_base] = 1'b0;
        m_base = (m_base + 1) & 63;
      end
      if (ok && !IN_isLoad) begin
        s = IN_storeSqN;
        m_v[s] = 1'b1; m_sqn[s] = IN_sqN; m_addr[s] = IN_addr[31:2];
        m_data[s] = IN_data; m_mask[s] = IN_wmask;
      end
    end
    @(posedge clk);
    #1;
    check("fwdValid", {31'd0, OUT_fwdValid}, {31'd0, eld});
    check("fwdMask", {28'd0, OUT_fwdMask}, {28'd0, emask});
    bmask = {{8{emask[3]}}, {8{emask[2]}}, {8{emask[1]}}, {8{emask[0]}}};
    if (eld && emask != 0) check("fwdData", OUT_fwdData & bmask, edata);
    s = 0;
    for (int i = 0; i < 64; i++) if (m_v[i]) s++;
    check("empty", {31'd0, OUT_empty}, {31'd0, s == 0});
    check("maxStoreSqN", {26'd0, OUT_maxStoreSqN}, 32'((m_base + N - 1) & 63));
  endtask

  initial begin
    int cur, nssqn, cmt, r, live, cnt, b, sidx;
    model_reset();
    idle();
    rst = 1; commitSqN = 0; IN_memReady = 0;
    @(posedge clk); #1;
    step(); step();
    check("rst_empty", {31'd0, OUT_empty}, 32'd1);
    check("rst_max", {26'd0, OUT_maxStoreSqN}, 32'd7);
    check("rst_fwdValid", {31'd0, OUT_fwdValid}, 32'd0);
    check("rst_memValid", {31'd0, OUT_memValid}, 32'd0);
    rst = 0;

    // Single store, commit, drain in the same cycle it becomes committed.
    st(3, 0, 32'h100, 32'hAABBCCDD, 4'hF); commitSqN = 3; IN_memReady = 1; step();
    idle(); commitSqN = 4; #1;
    check("t1_memValid", {31'd0, OUT_memValid}, 32'd1);
    check("t1_memAddr", OUT_memAddr, 32'h100);
    check("t1_memData", OUT_memData, 32'hAABBCCDD);
    step();
    check("t1_empty", {31'd0, OUT_empty}, 32'd1);
    check("t1_max", {26'd0, OUT_maxStoreSqN}, 32'd8);

    // Byte merge from two stores, and a load older than both stores.
    commitSqN = 1; IN_memReady = 0;
    st(2, 1, 32'h40, 32'h1111, 4'h3); step();
    st(4, 2, 32'h40, 32'h22, 4'h1); step();
    ld(6, 32'h40); step();
    check("t2_fwdMask", {28'd0, OUT_fwdMask}, 32'h3);
    check("t2_fwdData", {16'd0, OUT_fwdData[15:0]}, 32'h1122);
    ld(1, 32'h40); step();
    check("t3_fwdValid", {31'd0, OUT_fwdValid}, 32'd1);
    check("t3_fwdMask", {28'd0, OUT_fwdMask}, 32'h0);
    idle(); commitSqN = 5; IN_memReady = 1; step(); step();
    check("t3_drained", {31'd0, OUT_empty}, 32'd1);

    // Branch invalidates younger stores; rewound storeSqN reuses the freed slot.
    commitSqN = 10; IN_memReady = 0;
    st(10, 3, 32'h80, 32'hA0A0A0A0, 4'hF); step();
    st(12, 4, 32'h80, 32'hB0B0B0B0, 4'hF); step();
    st(14, 5, 32'h80, 32'hC0C0C0C0, 4'hF); step();
    idle(); bv = 1; bsqn = 11; bssqn = 4; commitSqN = 11; IN_memReady = 1; #1;
    check("t4_noDrainOnBranch", {31'd0, OUT_memValid}, 32'd0);
    step();
    idle(); IN_memReady = 0; ld(16, 32'h80); step();
    check("t4_fwdSurvivor", OUT_fwdData, 32'hA0A0A0A0);
    st(12, 4, 32'h80, 32'hD0D0D0D0, 4'h3); step();
    idle(); commitSqN = 20; IN_memReady = 1; #1;
    check("t4_head", OUT_memData, 32'hA0A0A0A0);
    step(); #1;
    check("t4_second", OUT_memData, 32'hD0D0D0D0);
    step();
    idle(); bv = 1; bflush = 1; bsqn = 20; bssqn = 20; step();
    check("flush_max", {26'd0, OUT_maxStoreSqN}, 32'd27);

    // sqN wrap: store 62 is older than load 0 and commit 1.
    idle(); commitSqN = 62; IN_memReady = 0;
    st(62, 20, 32'h200, 32'h12345678, 4'hF); step();
    ld(0, 32'h200); step();
    check("t5_fwdMask", {28'd0, OUT_fwdMask}, 32'hF);
    check("t5_fwdData", OUT_fwdData, 32'h12345678);
    idle(); commitSqN = 1; IN_memReady = 1; #1;
    check("t5_memValid", {31'd0, OUT_memValid}, 32'd1);
    step();

    // Stall with committed head, then reset mid-stall.
    st(5, 21, 32'h300, 32'h55, 4'h1); commitSqN = 6; IN_memReady = 0; step();
    idle();
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t6_held", {31'd0, OUT_memValid}, 32'd1);
      step();
    end
    rst = 1; step();
    check("t6_memValid", {31'd0, OUT_memValid}, 32'd0);
    check("t6_empty", {31'd0, OUT_empty}, 32'd1);
    check("t6_max", {26'd0, OUT_maxStoreSqN}, 32'd7);
    check("t6_fwdMask", {28'd0, OUT_fwdMask}, 32'd0);
    rst = 0;

    // Random traffic: stores, loads, commits, stalls and wrong-path branches.
    cur = 0; nssqn = 0; cmt = 0; commitSqN = 0;
    for (int c = 0; c < 3000; c++) begin
      idle();
      IN_memReady = ($urandom_range(0, 3) != 0);
      if (cur != cmt && $urandom_range(0, 2) == 0)
        cmt = (cmt + $urandom_range(1, sd(cur, cmt))) & 63;
      commitSqN = 6'(cmt);
      r = $urandom_range(0, 99);
      live = m_v[m_base] ? sd(cur, m_sqn[m_base]) : 0;
      if (sd(cur, cmt) < 20 && live < 20) begin
        if (r < 7 && cur != cmt) begin
          b = (cmt + $urandom_range(0, sd(cur, cmt) - 1)) & 63;
          cnt = 0;
          for (int j = 0; j < N; j++) begin
            sidx = (m_base + j) & 63;
            if (m_v[sidx] && sd(m_sqn[sidx], b) <= 0) cnt++;
          end
          bv = 1; bsqn = 6'(b); bssqn = 6'((m_base + cnt) & 63);
          if ($urandom_range(0, 1) == 1)
            st(cur, nssqn, 32'h1000, $urandom, 4'hF);
          cur = (b + 1) & 63;
          nssqn = (m_base + cnt) & 63;
        end else if (r < 40 && ((nssqn - m_base) & 63) < N) begin
          st(cur, nssqn, 32'h1000 + ($urandom_range(0, 3) << 2) + $urandom_range(0, 3),
             $urandom, 4'($urandom_range(1, 15)));
          cur = (cur + 1) & 63;
          nssqn = (nssqn + 1) & 63;
        end else if (r < 70) begin
          ld(cur, 32'h1000 + ($urandom_range(0, 3) << 2));
          cur = (cur + 1) & 63;
        end
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
